// File: rtl/hough_peaks_pkg.sv
// Shared Hough globals and the line_t payload handed to the overlay stage.
// Optional macro used by this block: HOUGH_PEAKS_SEPARATION_EN.
package hough_peaks_pkg;

    localparam int unsigned RHO_RANGE = 1024;
    localparam int unsigned THETAS    = 180;
    localparam int unsigned RHO_W     = $clog2(RHO_RANGE);
    localparam int unsigned THETA_W   = $clog2(THETAS);
    localparam int unsigned VOTE_W    = 16;

    typedef struct packed {
        logic [RHO_W-1:0]   rho;
        logic [THETA_W-1:0] theta;
        logic [VOTE_W-1:0]  votes;
    } line_t;

    function automatic logic [RHO_W-1:0] rho_dist(input logic [RHO_W-1:0] a,
                                                  input logic [RHO_W-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic logic [THETA_W-1:0] theta_dist(input logic [THETA_W-1:0] a,
                                                      input logic [THETA_W-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

endpackage

// File: rtl/hough_peaks_if.sv
// Accumulator read port plus output FIFO write port of the peak finder.
interface hough_peaks_if import hough_peaks_pkg::*; #(
    parameter int unsigned ADDR_W = $clog2(RHO_RANGE * THETAS)
) ();
    logic [ADDR_W-1:0] accum_rd_addr;
    logic [15:0]       accum_rd_data;
    logic              out_wr_en;
    logic              out_full;
    line_t             out_din;

    modport master (output accum_rd_addr, out_wr_en, out_din,
                    input  accum_rd_data, out_full);
    modport slave  (input  accum_rd_addr, out_wr_en, out_din,
                    output accum_rd_data, out_full);
endinterface

// File: rtl/hough_peaks_sorter.sv
// K-entry descending top-K list with single-cycle insertion.
// HOUGH_PEAKS_SEPARATION_EN adds neighbourhood suppression before insertion.
module hough_peaks_sorter import hough_peaks_pkg::*; #(
    parameter int unsigned NUM_LINES = 4
`ifdef HOUGH_PEAKS_SEPARATION_EN
    ,
    parameter int unsigned RHO_SEP   = 8,
    parameter int unsigned THETA_SEP = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 cand_valid_i,
    input  line_t                cand_i,
    output line_t                entries_o [NUM_LINES],
    output logic [NUM_LINES-1:0] valid_o
);

    line_t                ent_q  [NUM_LINES];
    line_t                ent_d  [NUM_LINES];
    line_t                base_e [NUM_LINES];
    logic [NUM_LINES-1:0] val_q, val_d, base_v;
    logic                 keep;
    int                   pos;
`ifdef HOUGH_PEAKS_SEPARATION_EN
    logic                 near_hi, rm_found;
    int                   rm_idx;
`endif

    always_comb begin
        base_e = ent_q;
        base_v = val_q;
        keep   = cand_valid_i;
        pos    = int'(NUM_LINES);
`ifdef HOUGH_PEAKS_SEPARATION_EN
        // A stronger neighbour vetoes the candidate; otherwise the first weaker one is evicted.
        near_hi  = 1'b0;
        rm_found = 1'b0;
        rm_idx   = 0;
        for (int i = 0; i < int'(NUM_LINES); i++) begin
            if (val_q[i] && rho_dist(ent_q[i].rho, cand_i.rho) <= RHO_W'(RHO_SEP) &&
                theta_dist(ent_q[i].theta, cand_i.theta) <= THETA_W'(THETA_SEP)) begin
                if (ent_q[i].votes >= cand_i.votes) begin
                    near_hi = 1'b1;
                end else if (!rm_found) begin
                    rm_found = 1'b1;
                    rm_idx   = i;
                end
            end
        end
        if (near_hi) begin
            keep = 1'b0;
        end else if (rm_found) begin
            for (int i = 0; i < int'(NUM_LINES) - 1; i++) begin
                if (i >= rm_idx) begin
                    base_e[i] = ent_q[i+1];
                    base_v[i] = val_q[i+1];
                end
            end
            base_v[NUM_LINES-1] = 1'b0;
        end
`endif
        // Strictly-less compare keeps the earlier bin ahead on ties.
        for (int i = int'(NUM_LINES) - 1; i >= 0; i--) begin
            if (!base_v[i] || base_e[i].votes < cand_i.votes) pos = i;
        end

        ent_d = ent_q;
        val_d = val_q;
        if (keep && pos < int'(NUM_LINES)) begin
            ent_d[0] = (pos == 0) ? cand_i : base_e[0];
            val_d[0] = (pos == 0) ? 1'b1   : base_v[0];
            for (int i = 1; i < int'(NUM_LINES); i++) begin
                if (i == pos) begin
                    ent_d[i] = cand_i;
                    val_d[i] = 1'b1;
                end else if (i > pos) begin
                    ent_d[i] = base_e[i-1];
                    val_d[i] = base_v[i-1];
                end else begin
                    ent_d[i] = base_e[i];
                    val_d[i] = base_v[i];
                end
            end
        end
        if (clear_i) begin
            for (int i = 0; i < int'(NUM_LINES); i++) ent_d[i] = '0;
            val_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_LINES); i++) ent_q[i] <= '0;
            val_q <= '0;
        end else begin
            ent_q <= ent_d;
            val_q <= val_d;
        end
    end

    assign entries_o = ent_q;
    assign valid_o   = val_q;

endmodule

// File: rtl/hough_peaks.sv
// Scans the Hough accumulator, keeps the strongest NUM_LINES bins and emits them to a FIFO.
// Optional macro: HOUGH_PEAKS_SEPARATION_EN (suppress peaks near a stronger kept peak).
module hough_peaks import hough_peaks_pkg::*; #(
    parameter int unsigned RHO_RANGE      = hough_peaks_pkg::RHO_RANGE,
    parameter int unsigned THETAS         = hough_peaks_pkg::THETAS,
    parameter int unsigned NUM_LINES      = 4,
    parameter logic [15:0] VOTE_THRESHOLD = 16'd50
`ifdef HOUGH_PEAKS_SEPARATION_EN
    ,
    parameter int unsigned RHO_SEP        = 8,
    parameter int unsigned THETA_SEP      = 4
`endif
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    hough_peaks_if.master                  bus,
    output logic [$clog2(NUM_LINES+1)-1:0] num_lines,
    output logic                           done
);

    localparam int unsigned ADDR_W = $clog2(RHO_RANGE * THETAS);
    localparam int unsigned NL_W   = $clog2(NUM_LINES + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SCAN  = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] EMIT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [RHO_W-1:0]   rho_q, rho_d, prho_q, prho_d;
    logic [THETA_W-1:0] theta_q, theta_d, ptheta_q, ptheta_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               pv_q, pv_d;
    logic [NL_W-1:0]    e_q, e_d;
    logic               done_q, done_d;
    logic               clear_c, wr_en_c, cand_valid_c;
    line_t              cand_c, sel_line;
    logic               sel_valid;
    logic [NL_W-1:0]    cnt;
    line_t              entries [NUM_LINES];
    logic [NUM_LINES-1:0] valid;

    assign cand_c       = '{rho: prho_q, theta: ptheta_q, votes: bus.accum_rd_data};
    assign cand_valid_c = pv_q && (bus.accum_rd_data >= VOTE_THRESHOLD);

    hough_peaks_sorter #(
        .NUM_LINES (NUM_LINES)
`ifdef HOUGH_PEAKS_SEPARATION_EN
        ,
        .RHO_SEP   (RHO_SEP),
        .THETA_SEP (THETA_SEP)
`endif
    ) u_sorter (
        .clk          (clock),
        .rst_n        (reset),
        .clear_i      (clear_c),
        .cand_valid_i (cand_valid_c),
        .cand_i       (cand_c),
        .entries_o    (entries),
        .valid_o      (valid)
    );

    // Emission pointer select; e_q == NUM_LINES yields an invalid entry.
    always_comb begin
        sel_line  = '0;
        sel_valid = 1'b0;
        cnt       = '0;
        for (int i = 0; i < int'(NUM_LINES); i++) begin
            if (e_q == NL_W'(i)) begin
                sel_line  = entries[i];
                sel_valid = valid[i];
            end
            cnt = cnt + NL_W'(valid[i]);
        end
    end

    always_comb begin
        state_d  = state_q;
        rho_d    = rho_q;
        theta_d  = theta_q;
        addr_d   = addr_q;
        pv_d     = 1'b0;
        prho_d   = prho_q;
        ptheta_d = ptheta_q;
        e_d      = e_q;
        done_d   = done_q;
        clear_c  = 1'b0;
        wr_en_c  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    clear_c = 1'b1;
                    done_d  = 1'b0;
                    rho_d   = '0;
                    theta_d = '0;
                    addr_d  = '0;
                    e_d     = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                pv_d     = 1'b1;
                prho_d   = rho_q;
                ptheta_d = theta_q;
                addr_d   = addr_q + ADDR_W'(1);
                if (theta_q == THETA_W'(THETAS - 1)) begin
                    theta_d = '0;
                    rho_d   = rho_q + RHO_W'(1);
                end else begin
                    theta_d = theta_q + THETA_W'(1);
                end
                if (rho_q == RHO_W'(RHO_RANGE - 1) && theta_q == THETA_W'(THETAS - 1)) begin
                    rho_d   = '0;
                    theta_d = '0;
                    addr_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                e_d     = '0;
                state_d = EMIT;
            end
            EMIT: begin
                if (!sel_valid) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (!bus.out_full) begin
                    wr_en_c = 1'b1;
                    e_d     = e_q + NL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rho_q    <= '0;
            theta_q  <= '0;
            addr_q   <= '0;
            pv_q     <= 1'b0;
            prho_q   <= '0;
            ptheta_q <= '0;
            e_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rho_q    <= rho_d;
            theta_q  <= theta_d;
            addr_q   <= addr_d;
            pv_q     <= pv_d;
            prho_q   <= prho_d;
            ptheta_q <= ptheta_d;
            e_q      <= e_d;
            done_q   <= done_d;
        end
    end

    assign bus.accum_rd_addr = addr_q;
    assign bus.out_wr_en     = wr_en_c;
    assign bus.out_din       = (state_q == EMIT) ? sel_line : '0;
    assign num_lines         = (state_q == EMIT || state_q == DONE) ? cnt : '0;
    assign done              = done_q;

endmodule

// File: tb/tb_hough_peaks.sv
// Scoreboard bench for hough_peaks on an 8x4 accumulator with a 4-entry list.
module tb_hough_peaks;
    import hough_peaks_pkg::*;

    localparam int RR  = 8;
    localparam int TT  = 4;
    localparam int K   = 4;
    localparam int NB  = RR * TT;
    localparam int AW  = $clog2(NB);
    localparam int NLW = $clog2(K + 1);
    localparam logic [15:0] THR = 16'd50;
    localparam int RS  = 2;
    localparam int TS  = 1;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [NLW-1:0] num_lines;
    logic           done;
    logic [15:0]    mem [NB];
    line_t          exp_q [$];
    line_t          mon_exp;
    int             exp_n = 0;
    int             n_run = 0;
    int             n_fail = 0;

    hough_peaks_if #(.ADDR_W(AW)) bus ();

    hough_peaks #(
        .RHO_RANGE      (RR),
        .THETAS         (TT),
        .NUM_LINES      (K),
        .VOTE_THRESHOLD (THR)
`ifdef HOUGH_PEAKS_SEPARATION_EN
        ,
        .RHO_SEP        (RS),
        .THETA_SEP      (TS)
`endif
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .num_lines (num_lines),
        .done      (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) bus.accum_rd_data <= mem[bus.accum_rd_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (bus.out_full) check("wr_while_full", 64'(bus.out_wr_en), 64'd0);
            if (bus.out_wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(bus.out_wr_en), 64'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("fifo_word", 64'(bus.out_din), 64'(mon_exp));
                end
            end
        end
    end

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Reference: walk bins in address order maintaining a descending list.
    task automatic build_expected();
        line_t lst [$];
        line_t c;
        int    p;
        bit    disc;
        int    rm;
        exp_q.delete();
        for (int a = 0; a < NB; a++) begin
            if (mem[a] < THR) continue;
            c.rho   = RHO_W'(a / TT);
            c.theta = THETA_W'(a % TT);
            c.votes = mem[a];
            disc = 1'b0;
            rm   = -1;
`ifdef HOUGH_PEAKS_SEPARATION_EN
            for (int i = 0; i < lst.size(); i++) begin
                if (absd(int'(lst[i].rho), int'(c.rho)) <= RS &&
                    absd(int'(lst[i].theta), int'(c.theta)) <= TS) begin
                    if (lst[i].votes >= c.votes) disc = 1'b1;
                    else if (rm < 0) rm = i;
                end
            end
`endif
            if (disc) continue;
            if (rm >= 0) lst.delete(rm);
            p = lst.size();
            for (int i = lst.size() - 1; i >= 0; i--) if (lst[i].votes < c.votes) p = i;
            if (p < K) begin
                lst.insert(p, c);
                if (lst.size() > K) void'(lst.pop_back());
            end
        end
        foreach (lst[i]) exp_q.push_back(lst[i]);
        exp_n = lst.size();
    endtask

    task automatic clear_mem();
        for (int a = 0; a < NB; a++) mem[a] = 16'd0;
    endtask

    task automatic run(input string name, input bit stall);
        int cyc;
        build_expected();
        @(posedge clock); #1;
        start = 1'b1;
        if (stall) bus.out_full = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check({name, "_done_clr"}, 64'(done), 64'd0);
        cyc = 0;
        while (!done && cyc < 400) begin
            @(posedge clock); #1;
            cyc++;
            if (stall && cyc == NB + 12) bus.out_full = 1'b0;
        end
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_num_lines"}, 64'(num_lines), 64'(exp_n));
        if (!stall) check({name, "_cycles"}, 64'(cyc), 64'(NB + 2 + exp_n));
        check({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
        bus.out_full = 1'b0;
    endtask

    initial begin
        bus.out_full = 1'b0;
        clear_mem();
        #12;
        check("rst_done", 64'(done), 64'd0);
        check("rst_num_lines", 64'(num_lines), 64'd0);
        check("rst_wr_en", 64'(bus.out_wr_en), 64'd0);
        check("rst_addr", 64'(bus.accum_rd_addr), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // three peaks, descending order
        clear_mem();
        mem[5] = 16'd100; mem[9] = 16'd70; mem[20] = 16'd90;
        run("t1", 1'b0);

        clear_mem();
        run("t2_empty", 1'b0);

        clear_mem();
        mem[0] = 16'd60; mem[3] = 16'd60; mem[7] = 16'd60;
        mem[11] = 16'd60; mem[15] = 16'd60; mem[31] = 16'd60;
        run("t3_ties", 1'b0);

        clear_mem();
        mem[5] = 16'd100; mem[9] = 16'd70; mem[20] = 16'd90;
        run("t4_full", 1'b1);

        // abort mid-scan, then rerun from clean state
        build_expected();
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        #2;
        check("t5_abort_addr", 64'(bus.accum_rd_addr), 64'd0);
        check("t5_abort_done", 64'(done), 64'd0);
        check("t5_abort_wr", 64'(bus.out_wr_en), 64'd0);
        check("t5_abort_nl", 64'(num_lines), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        run("t5_rerun", 1'b0);

        clear_mem();
        mem[5] = 16'd100; mem[9] = 16'd95; mem[27] = 16'd80;
        run("t6_near", 1'b0);

        clear_mem();
        mem[4] = 16'd49; mem[8] = 16'd50; mem[12] = 16'd65535;
        run("t7_thresh", 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < NB; a++)
                mem[a] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(40, 120)) : 16'd0;
            run("rnd", 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
